// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: width defaults, ALU opcode encoding
// and the control-field encoding of a pipeline bubble.
package ex_pkg;

   localparam int DEF_BUS_WIDTH = 32;
   localparam int DEF_OP_BITS   = 4;
   localparam int DEF_REG_BITS  = 5;

   typedef enum logic [3:0] {
      ALU_SLL = 4'b0000,
      ALU_SRL = 4'b0001,
      ALU_SRA = 4'b0010,
      ALU_ADD = 4'b0011,
      ALU_AND = 4'b0100,
      ALU_OR  = 4'b0101,
      ALU_XOR = 4'b0110,
      ALU_NOR = 4'b0111,
      ALU_SUB = 4'b1000,
      ALU_SLT = 4'b1001
   } alu_op_e;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } ex_ctrl_t;

   // A bubble carries no side effects; its data fields (result, store data, rd, zero) are all cleared.
   localparam ex_ctrl_t EX_CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};
   localparam logic     BUBBLE_ZERO    = 1'b0;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; results wrap modulo 2^BUS_WIDTH.
module alu
   import ex_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int OP_BITS   = DEF_OP_BITS
)(
   input  logic [BUS_WIDTH-1:0] a,
   input  logic [BUS_WIDTH-1:0] b,
   input  logic [OP_BITS-1:0]   opcode,
   output logic [BUS_WIDTH-1:0] result_out,
   output logic                 zero_flag
);

   localparam int SH_BITS = $clog2(BUS_WIDTH);

   logic [SH_BITS-1:0] shamt_s;
   logic               slt_s;
   logic               cmp_op_s;

   assign shamt_s  = b[SH_BITS-1:0];
   assign slt_s    = ($signed(a) < $signed(b)) ? 1'b1 : 1'b0;
   assign cmp_op_s = (opcode == OP_BITS'(ALU_SUB)) || (opcode == OP_BITS'(ALU_SLT));

   // Operation select; undefined opcodes yield zero.
   always_comb begin
      result_out = '0;
      case (opcode)
         OP_BITS'(ALU_SLL): result_out = a << shamt_s;
         OP_BITS'(ALU_SRL): result_out = a >> shamt_s;
         OP_BITS'(ALU_SRA): result_out = $unsigned($signed(a) >>> shamt_s);
         OP_BITS'(ALU_ADD): result_out = a + b;
         OP_BITS'(ALU_AND): result_out = a & b;
         OP_BITS'(ALU_OR):  result_out = a | b;
         OP_BITS'(ALU_XOR): result_out = a ^ b;
         OP_BITS'(ALU_NOR): result_out = ~(a | b);
         OP_BITS'(ALU_SUB): result_out = a - b;
         OP_BITS'(ALU_SLT): result_out = BUS_WIDTH'(slt_s);
         default:           result_out = '0;
      endcase
   end

   // Zero flag is only meaningful for the comparing operations.
   always_comb begin
      if (cmp_op_s && (a == b)) begin
         zero_flag = 1'b1;
      end else begin
         zero_flag = 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, load-use hazard detection, ALU and the
// EX/MEM output register with hold / bubble / capture priority.
module ex_stage
   import ex_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int OP_BITS   = DEF_OP_BITS,
   parameter int REG_BITS  = DEF_REG_BITS
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [BUS_WIDTH-1:0] id_rs_data,
   input  logic [BUS_WIDTH-1:0] id_rt_data,
   input  logic [BUS_WIDTH-1:0] id_imm,
   input  logic [REG_BITS-1:0]  id_rs,
   input  logic [REG_BITS-1:0]  id_rt,
   input  logic [REG_BITS-1:0]  id_rd,
   input  logic [OP_BITS-1:0]   id_opcode,
   input  logic                 id_alu_src,
   input  logic                 id_reg_write,
   input  logic                 id_mem_read,
   input  logic                 id_mem_write,
   input  logic                 wb_we,
   input  logic [REG_BITS-1:0]  wb_rd,
   input  logic [BUS_WIDTH-1:0] wb_data,
   input  logic                 mem_stall,
   input  logic                 flush,
   output logic                 hazard_stall,
   output logic                 ex_valid,
   output logic [BUS_WIDTH-1:0] ex_result,
   output logic                 ex_zero,
   output logic [BUS_WIDTH-1:0] ex_store_data,
   output logic [REG_BITS-1:0]  ex_rd,
   output logic                 ex_reg_write,
   output logic                 ex_mem_read,
   output logic                 ex_mem_write
);

   ex_ctrl_t             ctrl_r;
   logic [BUS_WIDTH-1:0] result_r;
   logic [BUS_WIDTH-1:0] store_data_r;
   logic                 zero_r;
   logic [REG_BITS-1:0]  rd_r;

   logic [BUS_WIDTH-1:0] fwd_a_s;
   logic [BUS_WIDTH-1:0] fwd_b_s;
   logic [BUS_WIDTH-1:0] op_b_s;
   logic [BUS_WIDTH-1:0] alu_result_s;
   logic                 alu_zero_s;
   logic                 exmem_src_s;
   logic                 wb_src_s;
   logic                 hazard_s;
   logic                 bubble_s;

   // EX/MEM outranks WB; a load still in EX has no data yet and cannot forward.
   function automatic logic [BUS_WIDTH-1:0] forward(
      input logic [REG_BITS-1:0]  src,
      input logic [BUS_WIDTH-1:0] reg_data,
      input logic                 exmem_ok,
      input logic [REG_BITS-1:0]  exmem_rd,
      input logic [BUS_WIDTH-1:0] exmem_val,
      input logic                 wb_ok,
      input logic [REG_BITS-1:0]  wb_addr,
      input logic [BUS_WIDTH-1:0] wb_val
   );
      logic [BUS_WIDTH-1:0] sel;
      if (exmem_ok && (exmem_rd == src)) begin
         sel = exmem_val;
      end else if (wb_ok && (wb_addr == src)) begin
         sel = wb_val;
      end else begin
         sel = reg_data;
      end
      return sel;
   endfunction

   assign exmem_src_s = ctrl_r.valid && ctrl_r.reg_write && !ctrl_r.mem_read && (rd_r != '0);
   assign wb_src_s    = wb_we && (wb_rd != '0);

   // Operand selection with bypass from EX/MEM and WB.
   always_comb begin
      fwd_a_s = forward(id_rs, id_rs_data, exmem_src_s, rd_r, result_r, wb_src_s, wb_rd, wb_data);
      fwd_b_s = forward(id_rt, id_rt_data, exmem_src_s, rd_r, result_r, wb_src_s, wb_rd, wb_data);
      if (id_alu_src) begin
         op_b_s = id_imm;
      end else begin
         op_b_s = fwd_b_s;
      end
   end

   // Load-use detection: rt only matters when it is read as an ALU operand or as store data.
   always_comb begin
      if (id_valid && ctrl_r.valid && ctrl_r.mem_read && (rd_r != '0) &&
          ((rd_r == id_rs) || ((rd_r == id_rt) && (!id_alu_src || id_mem_write)))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign bubble_s     = flush || hazard_s || !id_valid;
   assign hazard_stall = hazard_s;

   alu #(
      .BUS_WIDTH (BUS_WIDTH),
      .OP_BITS   (OP_BITS)
   ) u_alu (
      .a          (fwd_a_s),
      .b          (op_b_s),
      .opcode     (id_opcode),
      .result_out (alu_result_s),
      .zero_flag  (alu_zero_s)
   );

   // EX/MEM register: hold beats bubble beats capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_r       <= EX_CTRL_BUBBLE;
         result_r     <= '0;
         zero_r       <= BUBBLE_ZERO;
         store_data_r <= '0;
         rd_r         <= '0;
      end else if (mem_stall) begin
         ctrl_r       <= ctrl_r;
         result_r     <= result_r;
         zero_r       <= zero_r;
         store_data_r <= store_data_r;
         rd_r         <= rd_r;
      end else if (bubble_s) begin
         ctrl_r       <= EX_CTRL_BUBBLE;
         result_r     <= '0;
         zero_r       <= BUBBLE_ZERO;
         store_data_r <= '0;
         rd_r         <= '0;
      end else begin
         ctrl_r       <= '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write};
         result_r     <= alu_result_s;
         zero_r       <= alu_zero_s;
         store_data_r <= fwd_b_s;
         rd_r         <= id_rd;
      end
   end

   assign ex_valid      = ctrl_r.valid;
   assign ex_reg_write  = ctrl_r.reg_write;
   assign ex_mem_read   = ctrl_r.mem_read;
   assign ex_mem_write  = ctrl_r.mem_write;
   assign ex_result     = result_r;
   assign ex_zero       = zero_r;
   assign ex_store_data = store_data_r;
   assign ex_rd         = rd_r;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed scenarios plus randomized traffic
// against a behavioural reference model of forwarding, hazards and the ALU.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [3:0]  id_opcode;
   logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_stall, flush;
   logic        hazard_stall;
   logic        ex_valid, ex_zero, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [31:0] ex_result, ex_store_data;
   logic [4:0]  ex_rd;

   typedef struct {
      logic        valid;
      logic [31:0] result;
      logic        zero;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } exp_t;

   localparam exp_t BUBBLE = '{1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0};

   exp_t cur_m;
   exp_t mon_e;
   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic last_haz;

   ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_opcode(id_opcode),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_stall(mem_stall), .flush(flush), .hazard_stall(hazard_stall),
      .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, " valid"}, 32'(ex_valid), 32'd0);
      chk({tag, " result"}, ex_result, 32'd0);
      chk({tag, " zero"}, 32'(ex_zero), 32'd0);
      chk({tag, " store"}, ex_store_data, 32'd0);
      chk({tag, " rd"}, 32'(ex_rd), 32'd0);
      chk({tag, " reg_write"}, 32'(ex_reg_write), 32'd0);
      chk({tag, " mem_read"}, 32'(ex_mem_read), 32'd0);
      chk({tag, " mem_write"}, 32'(ex_mem_write), 32'd0);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
      if (r != 5'd0 && cur_m.valid && cur_m.rw && !cur_m.mr && cur_m.rd == r) return cur_m.result;
      else if (r != 5'd0 && wb_we && wb_rd == r) return wb_data;
      else return d;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = int'(b[4:0]);
      case (op)
         4'd0: return a << n;
         4'd1: return a >> n;
         4'd2: return a[31] ? ~((~a) >> n) : (a >> n);
         4'd3: return a + b;
         4'd4: return a & b;
         4'd5: return a | b;
         4'd6: return a ^ b;
         4'd7: return ~(a | b);
         4'd8: return a - b;
         4'd9: return (a[31] != b[31]) ? {31'd0, a[31]} : ((a < b) ? 32'd1 : 32'd0);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic model_hazard();
      return id_valid && cur_m.valid && cur_m.mr && cur_m.rd != 5'd0 &&
             (cur_m.rd == id_rs || (cur_m.rd == id_rt && (!id_alu_src || id_mem_write)));
   endfunction

   function automatic exp_t model_next(input logic haz);
      exp_t n;
      logic [31:0] a, rtv, b;
      if (mem_stall) return cur_m;
      if (flush || haz || !id_valid) return BUBBLE;
      a   = fwd(id_rs, id_rs_data);
      rtv = fwd(id_rt, id_rt_data);
      b   = id_alu_src ? id_imm : rtv;
      n.valid  = 1'b1;
      n.result = alu_ref(id_opcode, a, b);
      n.zero   = (id_opcode == 4'd8 || id_opcode == 4'd9) && (a == b);
      n.store  = rtv;
      n.rd     = id_rd;
      n.rw     = id_reg_write;
      n.mr     = id_mem_read;
      n.mw     = id_mem_write;
      return n;
   endfunction

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("ex_valid", 32'(ex_valid), 32'(mon_e.valid));
         chk("ex_result", ex_result, mon_e.result);
         chk("ex_zero", 32'(ex_zero), 32'(mon_e.zero));
         chk("ex_store_data", ex_store_data, mon_e.store);
         chk("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
         chk("ex_reg_write", 32'(ex_reg_write), 32'(mon_e.rw));
         chk("ex_mem_read", 32'(ex_mem_read), 32'(mon_e.mr));
         chk("ex_mem_write", 32'(ex_mem_write), 32'(mon_e.mw));
      end
   end

   // ---------------- driver helpers ----------------
   // Called just after a negedge with inputs already set; returns at the next negedge.
   task automatic cycle();
      logic haz;
      exp_t n;
      haz = model_hazard();
      #1;
      last_haz = hazard_stall;
      chk("hazard_stall", 32'(hazard_stall), 32'(haz));
      n = model_next(haz);
      exp_q.push_back(n);
      @(posedge clk);
      #2;
      cur_m = n;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      #1 rst = 1'b1;
      #1 chk_bubble("async_reset");
      cur_m = BUBBLE;
      #1 rst = 1'b0;
   endtask

   task automatic set_instr(input logic v, input logic [3:0] op,
                            input logic [4:0] rs, input logic [31:0] rsd,
                            input logic [4:0] rt, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic asrc, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw);
      id_valid = v; id_opcode = op; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
      id_imm = imm; id_alu_src = asrc; id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   function automatic logic [31:0] rand_data();
      case ($urandom_range(5))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return 32'($urandom_range(40));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      set_instr(1'b0, 4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; mem_stall = 1'b0; flush = 1'b0;
      cur_m = BUBBLE;
      repeat (2) @(negedge clk);
      chk_bubble("reset");
      rst = 1'b0;

      // add r8 = r5 + r6
      set_instr(1'b1, 4'd3, 5'd5, 32'd7, 5'd6, 32'd3, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("add result", ex_result, 32'd10);
      chk("add valid", 32'(ex_valid), 32'd1);
      chk("add rd", 32'(ex_rd), 32'd8);

      // sub r9 = r8 - r8 with stale operands and a competing WB source
      set_instr(1'b1, 4'd8, 5'd8, 32'd0, 5'd8, 32'd0, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'd99;
      cycle();
      chk("fwd sub result", ex_result, 32'd0);
      chk("fwd sub zero", 32'(ex_zero), 32'd1);
      chk("fwd store", ex_store_data, 32'd10);
      wb_we = 1'b0;

      // load r4, then a dependent add: one bubble, then WB forwarding
      set_instr(1'b1, 4'd3, 5'd1, 32'd100, 5'd0, 32'd0, 32'd4, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
      cycle();
      set_instr(1'b1, 4'd3, 5'd4, 32'd0, 5'd2, 32'd5, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("load-use stall", 32'(last_haz), 32'd1);
      chk("load-use bubble", 32'(ex_valid), 32'd0);
      wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'd123;
      cycle();
      chk("load-use released", 32'(last_haz), 32'd0);
      chk("load-use add", ex_result, 32'd128);
      wb_we = 1'b0;

      // mem_stall hold with flush pending
      set_instr(1'b1, 4'd3, 5'd10, 32'd20, 5'd11, 32'd22, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      cycle();
      mem_stall = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_instr(1'b1, 4'd6, 5'd12, $urandom, 5'd13, $urandom, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
         cycle();
         chk("stall hold result", ex_result, 32'd42);
         chk("stall hold rd", 32'(ex_rd), 32'd3);
         chk("stall hold valid", 32'(ex_valid), 32'd1);
      end
      mem_stall = 1'b0;
      cycle();
      chk("flush squash", 32'(ex_valid), 32'd0);
      flush = 1'b0;
      set_instr(1'b1, 4'd5, 5'd14, 32'hF0, 5'd15, 32'h0F, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("or after flush", ex_result, 32'hFF);

      // asynchronous reset while valid, then arithmetic corner cases via r0 operands
      pulse_reset();
      set_instr(1'b1, 4'd3, 5'd0, 32'h7FFF_FFFF, 5'd0, 32'd1, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("add wrap", ex_result, 32'h8000_0000);
      set_instr(1'b1, 4'd9, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("slt signed", ex_result, 32'd1);
      chk("slt zero", 32'(ex_zero), 32'd0);
      set_instr(1'b1, 4'd2, 5'd0, 32'h8000_0000, 5'd0, 32'd0, 32'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("sra", ex_result, 32'hF800_0000);

      // a write to r0 must never be forwarded
      set_instr(1'b1, 4'd3, 5'd0, 32'd5, 5'd0, 32'd6, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      cycle();
      set_instr(1'b1, 4'd3, 5'd0, 32'd1, 5'd0, 32'd2, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("r0 not forwarded", ex_result, 32'd3);

      // randomized traffic over a small register window to provoke forwarding and hazards
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(99) == 0) pulse_reset();
         set_instr($urandom_range(99) < 85, 4'($urandom_range(15)),
                   5'($urandom_range(7)), rand_data(), 5'($urandom_range(7)), rand_data(),
                   rand_data(), 1'($urandom_range(1)), 5'($urandom_range(7)),
                   1'($urandom_range(1)), $urandom_range(4) == 0, $urandom_range(5) == 0);
         wb_we     = 1'($urandom_range(1));
         wb_rd     = 5'($urandom_range(7));
         wb_data   = rand_data();
         mem_stall = $urandom_range(9) == 0;
         flush     = $urandom_range(19) == 0;
         cycle();
      end

      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter BUS_WIDTH, 32, datapath width.
REQ-002 SHALL have parameter OP_BITS, 4, ALU opcode width.
REQ-003 SHALL have parameter REG_BITS, 5, register-address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port id_valid  input  1  ID/EX holds a real instruction.
REQ-007 SHALL have ports id_rs_data, id_rt_data, id_imm  input  BUS_WIDTH  register-file operands and sign-extended immediate.
REQ-008 SHALL have ports id_rs, id_rt, id_rd  input  REG_BITS  source and destination addresses.
REQ-009 SHALL have port id_opcode  input  OP_BITS  ALU operation code.
REQ-010 SHALL have ports id_alu_src, id_reg_write, id_mem_read, id_mem_write  input  1  operand-B select (1 = immediate) and control bits.
REQ-011 SHALL have ports wb_we  input  1, wb_rd  input  REG_BITS, wb_data  input  BUS_WIDTH  writeback forwarding source.
REQ-012 SHALL have ports mem_stall  input  1 (hold output register) and flush  input  1 (squash incoming instruction).
REQ-013 SHALL have port hazard_stall  output  1  combinational load-use stall request to upstream.
REQ-014 SHALL have registered outputs ex_valid 1, ex_result BUS_WIDTH, ex_zero 1, ex_store_data BUS_WIDTH, ex_rd REG_BITS, ex_reg_write 1, ex_mem_read 1, ex_mem_write 1.

Function
REQ-015 Operand A SHALL be forwarded rs value: ex_result if ex_valid, ex_reg_write, !ex_mem_read, ex_rd!=0, ex_rd==id_rs; else wb_data if wb_we, wb_rd!=0, wb_rd==id_rs; else id_rs_data.
REQ-016 Forwarded rt value SHALL be selected the same way using id_rt; EX/MEM source beats WB source.
REQ-017 Register 0 SHALL never be a forwarding target; operands addressing 0 use id_*_data unchanged.
REQ-018 Operand B SHALL be id_imm when id_alu_src=1, else forwarded rt; ex_store_data SHALL capture forwarded rt.
REQ-019 ALU opcodes: 0000 sll, 0001 srl, 0010 sra, 0011 add, 0100 and, 0101 or, 0110 xor, 0111 nor, 1000 sub, 1001 slt (signed, result 0/1); others result 0; wrap-around modulo 2^BUS_WIDTH, no overflow flag.
REQ-020 Zero flag SHALL be 1 only for opcodes 1000/1001 with A==B, else 0.
REQ-021 hazard_stall SHALL be 1 when id_valid, ex_valid, ex_mem_read, ex_rd!=0 and ex_rd equals id_rs, or equals id_rt with id_alu_src=0 or id_mem_write=1.
REQ-022 Output register update priority per edge: mem_stall=1 holds all outputs; else flush=1 or hazard_stall=1 or id_valid=0 loads a bubble; else loads the ALU result and controls.
REQ-023 Bubble SHALL be ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_rd=0, ex_result=0, ex_zero=0, ex_store_data=0.
REQ-024 Latency SHALL be one cycle from ID/EX inputs to ex_* outputs; throughput one instruction per cycle absent stalls.
REQ-025 When mem_stall and hazard_stall are both 1, hold SHALL win; hazard_stall remains asserted until the bubble is inserted.
REQ-026 flush asserted with mem_stall=1 SHALL have no effect; the flush source holds flush until mem_stall drops.

Reset
REQ-027 rst=1 SHALL immediately force all registered outputs to the bubble values of REQ-023, independent of clk.
REQ-028 Reset deasserted mid-pipeline SHALL resume capture on the first rising edge with rst=0; no instruction survives reset.

Structure
REQ-029 Opcode constants, width defaults and the bubble encoding SHALL live in shared package ex_pkg.
REQ-030 The datapath SHALL instantiate exactly one sub-module, alu (a, b, opcode, result_out, zero_flag); forwarding, hazard and pipeline-register logic stay in ex_stage.

Verification
REQ-031 add rs=5 (data 7), rt=6 (data 3), rd=8 -> next cycle ex_result=10, ex_valid=1, ex_rd=8.
REQ-032 back-to-back add to r8 then sub r9=r8-r8 with stale id data 0 -> second ex_result=0, ex_zero=1 (EX/MEM forward); with wb_rd=8 wb_data=99 also present, EX/MEM value still wins.
REQ-033 load to r4 followed by add using r4 -> hazard_stall=1 one cycle, bubble ex_valid=0, then add completes with wb-forwarded r4.
REQ-034 mem_stall=1 for 3 cycles with new inputs and flush=1 -> outputs unchanged all 3 cycles; after release, flush squashes the next capture.
REQ-035 rst pulsed between edges while ex_valid=1 -> outputs bubble immediately; add 0x7FFFFFFF+1 -> 0x80000000; slt -1,1 -> 1; sra 0x80000000 by 4 -> 0xF8000000.
